// File: rtl/sha_wb_fifo.sv
// sha_wb_fifo -- Wishbone slave front-end with input FIFO for a SHA-256 core.
//
// Software streams 32-bit message words into a FIFO. A feed FSM hands each
// complete 16-word block to the compression core. The resulting hash words
// can be read by direct address, or through an auto-incrementing pointer.
//
// Optional feature macro: SHA_IRQ_EN (block-done interrupt plus the irq_en
// register at 0x0C). When the macro is undefined, SHA_IRQ_O is tied to 0 and
// 0x0C reads as 0.
//
// Ports (sha_wb_fifo):
//   CLK_I      in   1      system clock
//   RST_N_I    in   1      asynchronous active-low reset
//   SHA_CYC_I  in   1      wishbone cycle (unused)
//   SHA_STB_I  in   1      strobe
//   SHA_WE_I   in   1      write enable
//   SHA_ADR_I  in   ADR_W  byte address
//   SHA_DAT_I  in   32     write data
//   SHA_SEL_I  in   4      byte select (ignored; only full words are accessed)
//   SHA_ACK_O  out  1      acknowledge, one cycle after the strobe
//   SHA_ERR_O  out  1      constant 0
//   SHA_RTY_O  out  1      constant 0
//   SHA_DAT_O  out  32     read data, valid in the ACK cycle
//   SHA_IRQ_O  out  1      block-done interrupt
//
// Ports (sha_core):
//   clk, rst_n   clock and asynchronous active-low reset
//   init         reload the chaining value with the SHA-256 IV and abort work
//   vld/din      one message word per cycle; 16 words make one block
//   done         one-cycle pulse when a block's compression has finished
//   hash         chaining value; word 0 is in [255:224]

module sha_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         vld,
    input  logic [31:0]  din,
    output logic         done,
    output logic [255:0] hash
);
    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic [31:0] h_reg [0:7];   // chaining value
    logic [31:0] s_reg [0:7];   // working variables a..h
    logic [31:0] w_reg [0:15];  // rolling schedule window, w_reg[0] = W[t]
    logic [3:0]  wcnt_reg;
    logic [5:0]  rnd_reg;
    logic        run_reg;
    logic        done_reg;
    logic [31:0] t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        t1 = s_reg[7] + (rotr(s_reg[4], 6) ^ rotr(s_reg[4], 11) ^ rotr(s_reg[4], 25))
           + ((s_reg[4] & s_reg[5]) ^ (~s_reg[4] & s_reg[6])) + K_TAB[rnd_reg] + w_reg[0];
        t2 = (rotr(s_reg[0], 2) ^ rotr(s_reg[0], 13) ^ rotr(s_reg[0], 22))
           + ((s_reg[0] & s_reg[1]) ^ (s_reg[0] & s_reg[2]) ^ (s_reg[1] & s_reg[2]));
        // W[t+16] from the window; shifted in so the window stays 16 deep
        w_new = (rotr(w_reg[14], 17) ^ rotr(w_reg[14], 19) ^ (w_reg[14] >> 10)) + w_reg[9]
              + (rotr(w_reg[1], 7) ^ rotr(w_reg[1], 18) ^ (w_reg[1] >> 3)) + w_reg[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV[i];
                s_reg[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w_reg[i] <= '0;
            wcnt_reg <= '0;
            rnd_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (init) begin
                for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
                wcnt_reg <= '0;
                rnd_reg  <= '0;
                run_reg  <= 1'b0;
            end else if (run_reg) begin
                for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
                w_reg[15] <= w_new;
                s_reg[0] <= t1 + t2;
                s_reg[1] <= s_reg[0];
                s_reg[2] <= s_reg[1];
                s_reg[3] <= s_reg[2];
                s_reg[4] <= s_reg[3] + t1;
                s_reg[5] <= s_reg[4];
                s_reg[6] <= s_reg[5];
                s_reg[7] <= s_reg[6];
                rnd_reg  <= rnd_reg + 6'd1;
                if (rnd_reg == 6'd63) begin
                    // fold the last round's results straight into the chaining value
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                    h_reg[0] <= h_reg[0] + t1 + t2;
                    h_reg[1] <= h_reg[1] + s_reg[0];
                    h_reg[2] <= h_reg[2] + s_reg[1];
                    h_reg[3] <= h_reg[3] + s_reg[2];
                    h_reg[4] <= h_reg[4] + s_reg[3] + t1;
                    h_reg[5] <= h_reg[5] + s_reg[4];
                    h_reg[6] <= h_reg[6] + s_reg[5];
                    h_reg[7] <= h_reg[7] + s_reg[6];
                end
            end else if (vld) begin
                for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
                w_reg[15] <= din;
                wcnt_reg  <= wcnt_reg + 4'd1;
                if (wcnt_reg == 4'd15) begin
                    run_reg <= 1'b1;
                    rnd_reg <= '0;
                    for (int i = 0; i < 8; i++) s_reg[i] <= h_reg[i];
                end
            end
        end
    end

    assign done = done_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hash_out
            assign hash[255-32*gi -: 32] = h_reg[gi];
        end
    endgenerate
endmodule

module sha_wb_fifo #(
    parameter int ADR_W      = 6,
    parameter int FIFO_DEPTH = 32,
    parameter int FIFO_AW    = 5
) (
    input  logic             CLK_I,
    input  logic             RST_N_I,
    input  logic             SHA_CYC_I,
    input  logic             SHA_STB_I,
    input  logic             SHA_WE_I,
    input  logic [ADR_W-1:0] SHA_ADR_I,
    input  logic [31:0]      SHA_DAT_I,
    input  logic [3:0]       SHA_SEL_I,
    output logic             SHA_ACK_O,
    output logic             SHA_ERR_O,
    output logic             SHA_RTY_O,
    output logic [31:0]      SHA_DAT_O,
    output logic             SHA_IRQ_O
);
    localparam logic [ADR_W-1:0] A_CTRL  = ADR_W'(8'h00);
    localparam logic [ADR_W-1:0] A_PUSH  = ADR_W'(8'h04);
    localparam logic [ADR_W-1:0] A_HAUTO = ADR_W'(8'h08);
    localparam logic [ADR_W-1:0] A_IRQ   = ADR_W'(8'h0C);
    localparam logic [ADR_W-1:0] A_HASH  = ADR_W'(8'h20);
    localparam logic [ADR_W-1:0] A_HMASK = ADR_W'(8'h1C);
    localparam logic [FIFO_AW:0] LVL_BLOCK = (FIFO_AW+1)'(16);
    localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_FEED, S_WAIT} state_t;
    state_t state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [31:0]        fifo_mem [0:FIFO_DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   level_reg;
    logic               ack_reg, done_reg, ovf_reg;
    logic [31:0]        dat_reg, rd_data;
    logic [2:0]         hash_ptr_reg;
    logic               core_init, core_vld, core_done;
    logic [255:0]       core_hash;
    logic [31:0]        hash_w [0:7];

    wire unused_bus = &{1'b0, SHA_CYC_I, SHA_SEL_I};

    // Bus decode: every side effect happens on the first strobe cycle only
    wire bus_req   = SHA_STB_I & ~ack_reg;
    wire wr_req    = bus_req & SHA_WE_I;
    wire rd_req    = bus_req & ~SHA_WE_I;
    wire hash_sel  = (SHA_ADR_I & ~A_HMASK) == A_HASH;
    wire init_req  = wr_req & (SHA_ADR_I == A_CTRL) & SHA_DAT_I[0];
    wire clr_done  = wr_req & (SHA_ADR_I == A_CTRL) & SHA_DAT_I[1];
    wire clr_ovf   = wr_req & (SHA_ADR_I == A_CTRL) & SHA_DAT_I[2];
    wire push_req  = wr_req & (SHA_ADR_I == A_PUSH) & ~init_req;
    wire auto_rd   = rd_req & (SHA_ADR_I == A_HAUTO);
    wire pop       = (state_reg == S_FEED);
    wire full      = (level_reg == LVL_FULL);
    wire empty     = (level_reg == '0);
    wire busy      = (state_reg != S_IDLE);
    // a pop in the same cycle frees the slot a full FIFO needs
    wire push_ok   = push_req & (~full | pop);
    wire push_drop = push_req & full & ~pop;
    wire done_evt  = (state_reg == S_WAIT) & core_done;

    sha_core u_core (
        .clk   (CLK_I),
        .rst_n (RST_N_I),
        .init  (core_init),
        .vld   (core_vld),
        .din   (fifo_mem[rd_ptr_reg]),
        .done  (core_done),
        .hash  (core_hash)
    );

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hash_w
            assign hash_w[gi] = core_hash[255-32*gi -: 32];
        end
    endgenerate

    always_ff @(posedge CLK_I) begin
        if (push_ok) fifo_mem[wr_ptr_reg] <= SHA_DAT_I;
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (init_req) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_ok && !pop)      level_reg <= level_reg + 1'b1;
            else if (!push_ok && pop) level_reg <= level_reg - 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        core_init  = 1'b0;
        core_vld   = 1'b0;
        case (state_reg)
            S_IDLE: if (level_reg >= LVL_BLOCK) begin
                state_next = S_FEED;
                cnt_next   = '0;
            end
            S_INIT: begin
                core_init  = 1'b1;
                state_next = S_IDLE;
            end
            S_FEED: begin
                core_vld = 1'b1;
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) state_next = S_WAIT;
            end
            S_WAIT: if (core_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // an INIT write aborts whatever block is in flight
        if (init_req) state_next = S_INIT;
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            ack_reg      <= 1'b0;
            dat_reg      <= '0;
            done_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            hash_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= SHA_STB_I & ~ack_reg;
            dat_reg   <= rd_req ? rd_data : '0;
            // INIT beats a done from the aborted block; a done beats clear-DONE
            if (init_req)      done_reg <= 1'b0;
            else if (done_evt) done_reg <= 1'b1;
            else if (clr_done) done_reg <= 1'b0;
            if (init_req)       ovf_reg <= 1'b0;
            else if (push_drop) ovf_reg <= 1'b1;
            else if (clr_ovf)   ovf_reg <= 1'b0;
            if (init_req)     hash_ptr_reg <= '0;
            else if (auto_rd) hash_ptr_reg <= hash_ptr_reg + 3'd1;
        end
    end

`ifdef SHA_IRQ_EN
    logic irq_en_reg, irq_reg;
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_req && SHA_ADR_I == A_IRQ) irq_en_reg <= SHA_DAT_I[0];
            irq_reg <= done_reg & irq_en_reg;
        end
    end
    assign SHA_IRQ_O = irq_reg;
`else
    assign SHA_IRQ_O = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (SHA_ADR_I == A_CTRL)
            rd_data = {8'h00, 8'(level_reg), 11'd0, ovf_reg, empty, full, done_reg, busy};
        else if (SHA_ADR_I == A_HAUTO)
            rd_data = hash_w[hash_ptr_reg];
`ifdef SHA_IRQ_EN
        else if (SHA_ADR_I == A_IRQ)
            rd_data = {31'd0, irq_en_reg};
`endif
        else if (hash_sel)
            rd_data = hash_w[SHA_ADR_I[4:2]];
    end

    assign SHA_ACK_O = ack_reg;
    assign SHA_DAT_O = dat_reg;
    assign SHA_ERR_O = 1'b0;
    assign SHA_RTY_O = 1'b0;
endmodule

// File: tb/tb_sha_wb_fifo.sv
`timescale 1ns/1ps
module tb_sha_wb_fifo;
    logic        CLK_I = 1'b0;
    logic        RST_N_I = 1'b0;
    logic        SHA_CYC_I = 1'b0;
    logic        SHA_STB_I = 1'b0;
    logic        SHA_WE_I = 1'b0;
    logic [5:0]  SHA_ADR_I = '0;
    logic [31:0] SHA_DAT_I = '0;
    logic [3:0]  SHA_SEL_I = 4'hF;
    logic        SHA_ACK_O, SHA_ERR_O, SHA_RTY_O, SHA_IRQ_O;
    logic [31:0] SHA_DAT_O;

    always #5 CLK_I = ~CLK_I;

    sha_wb_fifo #(.ADR_W(6), .FIFO_DEPTH(32), .FIFO_AW(5)) dut (
        .CLK_I     (CLK_I),
        .RST_N_I   (RST_N_I),
        .SHA_CYC_I (SHA_CYC_I),
        .SHA_STB_I (SHA_STB_I),
        .SHA_WE_I  (SHA_WE_I),
        .SHA_ADR_I (SHA_ADR_I),
        .SHA_DAT_I (SHA_DAT_I),
        .SHA_SEL_I (SHA_SEL_I),
        .SHA_ACK_O (SHA_ACK_O),
        .SHA_ERR_O (SHA_ERR_O),
        .SHA_RTY_O (SHA_RTY_O),
        .SHA_DAT_O (SHA_DAT_O),
        .SHA_IRQ_O (SHA_IRQ_O)
    );

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } exp_t;

    exp_t        sb_q [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] last_rd;
    // SHA-256("abc")
    logic [31:0] abc_h [0:7] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                 32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    endtask

    // Monitor: every ACK consumes one scoreboard entry
    always @(negedge CLK_I) begin : monitor
        exp_t e;
        if (RST_N_I && SHA_ACK_O) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("ack %-16s dat=%08h", e.name, SHA_DAT_O);
                if (e.chk) check(e.name, SHA_DAT_O & e.mask, e.exp);
            end
        end
    end

    // One transaction: strobe for a single edge, then one idle edge (ACK cycle)
    task automatic bus(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                       input logic chk, input logic [31:0] exp, input logic [31:0] mask,
                       input string nm);
        exp_t e;
        e.chk = chk; e.exp = exp; e.mask = mask; e.name = nm;
        sb_q.push_back(e);
        SHA_CYC_I = 1'b1; SHA_STB_I = 1'b1; SHA_WE_I = we;
        SHA_ADR_I = adr;  SHA_DAT_I = dat;
        @(posedge CLK_I); #1;
        SHA_CYC_I = 1'b0; SHA_STB_I = 1'b0; SHA_WE_I = 1'b0;
        last_rd = SHA_DAT_O;
        @(posedge CLK_I); #1;
    endtask

    task automatic wr(input logic [5:0] adr, input logic [31:0] dat);
        bus(1'b1, adr, dat, 1'b0, 32'h0, 32'h0, "wr");
    endtask

    task automatic rd_chk(input logic [5:0] adr, input logic [31:0] exp, input string nm);
        bus(1'b0, adr, 32'h0, 1'b1, exp, 32'hFFFF_FFFF, nm);
    endtask

    task automatic rd_mask(input logic [5:0] adr, input logic [31:0] exp,
                           input logic [31:0] mask, input string nm);
        bus(1'b0, adr, 32'h0, 1'b1, exp, mask, nm);
    endtask

    task automatic poll_status(input logic [31:0] mask, input logic [31:0] val,
                               input int max_polls, input string nm);
        logic ok = 1'b0;
        for (int i = 0; i < max_polls && !ok; i++) begin
            bus(1'b0, 6'h00, 32'h0, 1'b0, 32'h0, 32'h0, "poll");
            if ((last_rd & mask) == val) ok = 1'b1;
        end
        check(nm, {31'd0, ok}, 32'd1);
    endtask

    task automatic push_seq(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) wr(6'h04, base + 32'(i));
    endtask

    task automatic push_abc();
        wr(6'h04, 32'h61626380);
        for (int i = 0; i < 14; i++) wr(6'h04, 32'h0);
        wr(6'h04, 32'h00000018);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge CLK_I);
        #1;
        check("rst_ack", {31'd0, SHA_ACK_O}, 32'd0);
        check("rst_dat", SHA_DAT_O, 32'd0);
        check("rst_irq", {31'd0, SHA_IRQ_O}, 32'd0);
        RST_N_I = 1'b1;
        @(posedge CLK_I); #1;
        rd_chk(6'h00, 32'h00000008, "reset_status");
        wr(6'h08, 32'hDEAD_BEEF);               // unmapped write, ignored
        rd_chk(6'h10, 32'h0, "unmapped_rd");

        // abc block
        wr(6'h00, 32'h1);
        push_abc();
        rd_mask(6'h00, 32'h01, 32'h1B, "abc_busy");
        poll_status(32'h3, 32'h2, 100, "abc_done");
        for (int i = 0; i < 8; i++) rd_chk(6'h08, abc_h[i], "abc_auto");
        rd_chk(6'h08, abc_h[0], "abc_wrap");
        rd_chk(6'h3C, abc_h[7], "abc_direct7");
        rd_chk(6'h20, abc_h[0], "abc_direct0");
        rd_chk(6'h08, abc_h[1], "abc_ptr_kept");
        rd_chk(6'h08, abc_h[2], "abc_ptr2");

        // reset pulse in the middle of feeding a block
        push_seq(16, 32'h1000_0000);
        repeat (4) @(posedge CLK_I);
        #1;
        RST_N_I = 1'b0;
        @(posedge CLK_I); #1;
        RST_N_I = 1'b1;
        check("rstfeed_irq", {31'd0, SHA_IRQ_O}, 32'd0);
        rd_chk(6'h00, 32'h00000008, "rstfeed_status");
        // reset puts the chaining value back to the SHA-256 initial hash
        rd_chk(6'h08, 32'h6a09e667, "rstfeed_hptr");
        repeat (100) @(posedge CLK_I);
        #1;
        rd_chk(6'h00, 32'h00000008, "rstfeed_idle");

        // overflow: fill the FIFO while the first block is in flight
        wr(6'h00, 32'h1);
        push_seq(16, 32'h2000_0000);
        push_seq(33, 32'h3000_0000);
        rd_chk(6'h00, 32'h00200015, "ovf_status");
        poll_status(32'h9, 32'h8, 400, "drain_done");
        rd_chk(6'h00, 32'h0000001A, "drain_status");
        wr(6'h00, 32'h4);
        rd_chk(6'h00, 32'h0000000A, "clr_ovf");
        wr(6'h00, 32'h2);
        rd_chk(6'h00, 32'h00000008, "clr_done");

        // INIT while a block is in WAIT with 10 more words queued
        wr(6'h00, 32'h1);
        push_seq(16, 32'h4000_0000);
        push_seq(10, 32'h5000_0000);
        rd_chk(6'h00, 32'h000A0001, "pre_abort");
        wr(6'h00, 32'h1);
        rd_chk(6'h00, 32'h00000008, "abort_status");
        repeat (120) @(posedge CLK_I);
        #1;
        rd_chk(6'h00, 32'h00000008, "abort_no_done");

        // interrupt
`ifdef SHA_IRQ_EN
        wr(6'h0C, 32'h1);
        rd_chk(6'h0C, 32'h1, "irq_en_rd");
        wr(6'h00, 32'h1);
        check("irq_idle", {31'd0, SHA_IRQ_O}, 32'd0);
        push_abc();
        poll_status(32'h3, 32'h2, 100, "irq_done");
        check("irq_high", {31'd0, SHA_IRQ_O}, 32'd1);
        rd_chk(6'h20, abc_h[0], "irq_hash");
        wr(6'h00, 32'h2);
        check("irq_low", {31'd0, SHA_IRQ_O}, 32'd0);
`else
        wr(6'h0C, 32'h1);
        rd_chk(6'h0C, 32'h0, "irq_reg_absent");
        wr(6'h00, 32'h1);
        push_abc();
        poll_status(32'h3, 32'h2, 100, "noirq_done");
        check("noirq_irq", {31'd0, SHA_IRQ_O}, 32'd0);
        rd_chk(6'h20, abc_h[0], "noirq_hash");
`endif

        repeat (4) @(posedge CLK_I);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
